// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin arbiter sharing one CLA16-based adder among NREQ requesters,
// with a one-entry tagged output register.
module adder_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx;
    logic [WIDTH-1:0] sum_q, sum_d, op_a, op_b, add_sum;
    logic             cout_q, cout_d, op_cin, add_cout, any, grant;

    // 4-bit groups with group generate/propagate feeding the group carry-out
    function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [15:0] g, p;
        logic [16:0] c;
        logic        gg, gp;
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
                gg = g[4*k+j] | (p[4*k+j] & gg);
                gp = gp & p[4*k+j];
            end
            c[4*k+4] = gg | (gp & c[4*k]);
        end
        return {c[16], p ^ c[15:0]};
    endfunction

    always_comb begin
        int idx;
        idx = 0;
        any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        grant = !rst && any && (state_q == EMPTY || rsp_ready);
        req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        logic c;
        op_a = req_a[gnt_idx*WIDTH +: WIDTH];
        op_b = req_b[gnt_idx*WIDTH +: WIDTH];
        op_cin = req_cin[gnt_idx];
        add_sum = '0;
        c = op_cin;
        for (int s = 0; s < WIDTH/16; s++)
            {c, add_sum[s*16 +: 16]} = cla16(op_a[s*16 +: 16], op_b[s*16 +: 16], c);
        add_cout = c;
    end

    always_comb begin
        state_d  = grant ? FULL : (rsp_ready ? EMPTY : state_q);
        rr_ptr_d = grant ? ((gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
        id_d     = grant ? gnt_idx : id_q;
        sum_d    = grant ? add_sum : sum_q;
        cout_d   = grant ? add_cout : cout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            id_q     <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed vectors; the driver queues expected results at each grant,
// the monitor compares them as the consumer takes each response.
module tb_adder_rr_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_cin = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;

    logic [31:0]  exp_sum [4];
    logic         exp_cout [4];
    logic [34:0]  sb [$];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NREQ(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [34:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0)
                chk("rsp_unexpected", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("rsp", {29'd0, rsp_id, rsp_cout, rsp_sum}, {29'd0, e});
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] s, input logic co);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_cin[i] = c;
        exp_sum[i] = s;
        exp_cout[i] = co;
    endtask

    task automatic cyc(input logic [3:0] v, input logic rr, input logic [3:0] er, input string name);
        req_valid = v;
        rsp_ready = rr;
        #3;
        chk(name, {60'd0, req_ready}, {60'd0, er});
        for (int i = 0; i < 4; i++)
            if (er[i]) sb.push_back({2'(i), exp_cout[i], exp_sum[i]});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #3;
        chk("rdy_in_rst", {60'd0, req_ready}, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_out", {29'd0, rsp_id, rsp_cout, rsp_sum}, 64'd0);
    endtask

    initial begin
        #1;
        do_reset();
        set_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0);
        cyc(4'b0001, 1'b1, 4'b0001, "g_basic");
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        cyc(4'b0001, 1'b1, 4'b0001, "g_wrap");
        set_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        cyc(4'b0001, 1'b1, 4'b0001, "g_msb");
        set_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
        cyc(4'b0001, 1'b1, 4'b0001, "g_slice");
        cyc(4'b0000, 1'b1, 4'b0000, "idle");
        do_reset();
        set_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0);
        set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0);
        set_op(2, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1);
        set_op(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0001, 1'b0);
        repeat (2) begin
            cyc(4'hF, 1'b1, 4'b0001, "rr0");
            cyc(4'hF, 1'b1, 4'b0010, "rr1");
            cyc(4'hF, 1'b1, 4'b0100, "rr2");
            cyc(4'hF, 1'b1, 4'b1000, "rr3");
        end
        repeat (3) begin
            cyc(4'hF, 1'b0, 4'b0000, "rdy_stall");
            chk("hold", {28'd0, rsp_valid, rsp_id, rsp_cout, rsp_sum}, {28'd0, 1'b1, 2'd3, 1'b0, 32'h8000_0001});
        end
        cyc(4'hF, 1'b1, 4'b0001, "regrant");
        chk("b2b_valid", {63'd0, rsp_valid}, 64'd1);
        cyc(4'hF, 1'b1, 4'b0010, "rr_next");
        cyc(4'b1000, 1'b1, 4'b1000, "only3");
        cyc(4'b0100, 1'b1, 4'b0100, "only2");
        cyc(4'hF, 1'b1, 4'b1000, "ptr_after2");
        do_reset();
        cyc(4'b1010, 1'b1, 4'b0010, "post_rst");
        cyc(4'b1000, 1'b1, 4'b1000, "post_rst3");
        cyc(4'b0000, 1'b1, 4'b0000, "drain");
        cyc(4'b0000, 1'b1, 4'b0000, "idle_end");
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
